main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm.sv | 131 +++++++++++++
 tb/tb_main_fsm.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// Multicycle processor control FSM: Moore sequencer that steps each instruction
// class through fetch, decode, execute and writeback, driving datapath selects and enables.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_e;

  state_e state_q, state_d;

  // Funct[4:1] carries ALU/condition detail consumed by other decoders only.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = '0;
    ALUSrcB   = '0;
    ResultSrc = '0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
    // Reset gates enables immediately and parks the muxes on fetch values,
    // so nothing is written during the cycle reset is being sampled.
    if (reset) begin
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 2'b01;
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
      ALUOp     = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: driver queues the expected per-cycle state and
// outputs for directed instruction sequences; a negedge monitor pops and compares.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .State(State)
  );

  always #5 clk = ~clk;

  // {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
  logic [16:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [12:0] exp_out(input logic [3:0] st, input logic rst);
    logic [12:0] o;
    if (rst) return 13'b0_0_01_10_10_0_0_0_0_0;
    case (st)
      4'd0:    o = 13'b1_0_01_10_10_1_0_0_0_0;
      4'd1:    o = 13'b0_0_01_10_10_0_0_0_0_0;
      4'd2:    o = 13'b0_0_00_01_00_0_0_0_0_0;
      4'd3:    o = 13'b0_1_00_00_00_0_0_0_0_0;
      4'd4:    o = 13'b0_0_00_00_01_0_1_0_0_0;
      4'd5:    o = 13'b0_1_00_00_00_0_0_1_0_0;
      4'd6:    o = 13'b0_0_00_00_00_0_0_0_0_1;
      4'd7:    o = 13'b0_0_00_01_00_0_0_0_0_1;
      4'd8:    o = 13'b0_0_00_00_00_0_1_0_0_0;
      4'd9:    o = 13'b0_0_00_01_10_0_0_0_1_0;
      default: o = '0;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    logic [16:0] act, e;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             NextPC, RegW, MemW, Branch, ALUOp};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL cycle_check t=%0t state/outputs got=%05h want=%05h", $time, act, e);
      end
    end
  end

  // One clock cycle: set inputs for the current state, queue its expectation.
  task automatic cycle(input logic [3:0] st, input logic rst, input logic [1:0] op,
                       input logic [5:0] fn, input bit tog);
    reset = rst;
    if (tog && st != 4'd1 && st != 4'd2) begin
      Op    = 2'($urandom_range(3, 0));
      Funct = 6'($urandom);
    end else begin
      Op    = op;
      Funct = fn;
    end
    exp_q.push_back({st, exp_out(st, rst)});
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] op, input logic [5:0] fn, input bit tog);
    logic [3:0] s[5];
    int unsigned n;
    case (op)
      2'b00: begin s = '{4'd0, 4'd1, (fn[5] ? 4'd7 : 4'd6), 4'd8, 4'd0}; n = 4; end
      2'b01: if (fn[0]) begin s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}; n = 5; end
             else       begin s = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0}; n = 4; end
      2'b10: begin s = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0}; n = 3; end
      default: begin s = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd0}; n = 3; end
    endcase
    for (int unsigned i = 0; i < n; i++) cycle(s[i], 1'b0, op, fn, tog);
  endtask

  initial begin
    reset = 1'b1;
    Op    = 2'b00;
    Funct = 6'b000000;
    @(posedge clk);
    #1;
    cycle(4'd0, 1'b1, 2'b00, 6'b000000, 1'b0);   // held in reset: FETCH, enables off

    total++;
    if (State !== 4'd0 || IRWrite !== 1'b0 || NextPC !== 1'b0 || RegW !== 1'b0 ||
        MemW !== 1'b0 || Branch !== 1'b0 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10 ||
        ResultSrc !== 2'b10) begin
      bad++;
      $display("FAIL reset_state t=%0t State=%0d IRWrite=%b NextPC=%b RegW=%b MemW=%b Branch=%b",
               $time, State, IRWrite, NextPC, RegW, MemW, Branch);
    end

    instr(2'b00, 6'b000000, 1'b0);               // data-processing register
    instr(2'b01, 6'b000001, 1'b0);               // LDR
    instr(2'b01, 6'b000000, 1'b0);               // STR
    instr(2'b10, 6'b000000, 1'b0);               // B
    instr(2'b11, 6'b000000, 1'b0);               // unsupported
    instr(2'b00, 6'b100000, 1'b0);               // data-processing immediate

    // reset mid-instruction in EXECUTEI, then resume from FETCH
    cycle(4'd0, 1'b0, 2'b00, 6'b100000, 1'b0);
    cycle(4'd1, 1'b0, 2'b00, 6'b100000, 1'b0);
    cycle(4'd7, 1'b1, 2'b00, 6'b100000, 1'b0);
    instr(2'b10, 6'b000000, 1'b0);

    // reset mid-LDR in MEMRD
    cycle(4'd0, 1'b0, 2'b01, 6'b000001, 1'b0);
    cycle(4'd1, 1'b0, 2'b01, 6'b000001, 1'b0);
    cycle(4'd2, 1'b0, 2'b01, 6'b000001, 1'b0);
    cycle(4'd3, 1'b1, 2'b01, 6'b000001, 1'b0);

    // inputs scrambled outside DECODE/MEMADR must not alter sequences
    for (int unsigned r = 0; r < 3; r++) begin
      instr(2'b01, 6'b000001, 1'b1);
      instr(2'b00, 6'b000000, 1'b1);
      instr(2'b01, 6'b100000, 1'b1);
      instr(2'b00, 6'b101010, 1'b1);
      instr(2'b10, 6'b000001, 1'b1);
      instr(2'b11, 6'b111111, 1'b1);
    end

    for (int unsigned w = 0; w < 8 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout t=%0t expectations left=%0d", $time, exp_q.size());
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
